// File: rtl/div_wb_unit_if.sv
// Issue/writeback bundle between the issue stage and the divide unit.
// slave = divide unit (responder); master = issue stage plus writeback arbitration.
interface div_wb_unit_if #(
    parameter int ScoreboardIndex = 3,
    parameter int DataWidth       = 32
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [1:0]                 in_op;
    logic [DataWidth-1:0]       in_rs1;
    logic [DataWidth-1:0]       in_rs2;
    logic [ScoreboardIndex-1:0] in_trans_id;
    logic                       wb_valid;
    logic                       wb_ready;
    logic [ScoreboardIndex-1:0] wb_idx;
    logic [DataWidth-1:0]       wb_data;
    logic                       busy;

    modport slave (
        input  flush, in_valid, in_op, in_rs1, in_rs2, in_trans_id, wb_ready,
        output in_ready, wb_valid, wb_idx, wb_data, busy
    );

    modport master (
        output flush, in_valid, in_op, in_rs1, in_rs2, in_trans_id, wb_ready,
        input  in_ready, wb_valid, wb_idx, wb_data, busy
    );
endinterface

// File: rtl/div_wb_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one op in flight, scoreboard writeback.
// Latency: accept at T -> wb_valid at T+33 (restoring divide) or T+1 (div-by-zero / overflow).
// Backpressure: in_ready only in IDLE without flush; result held in DONE until wb_ready.
module div_wb_unit #(
    parameter int ScoreboardIndex = 3,
    parameter int DataWidth       = 32
) (
    input logic          clock,
    input logic          reset,
    div_wb_unit_if.slave bus
);
    localparam int CntW = $clog2(DataWidth);
    localparam logic [DataWidth-1:0] MinNeg = {1'b1, {(DataWidth-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Everything about the accepted op that survives until writeback.
    typedef struct packed {
        logic                       is_rem;
        logic                       neg_res;
        logic [ScoreboardIndex-1:0] trans_id;
    } ctx_t;

    state_t               state_q, state_d;
    ctx_t                 ctx_q, ctx_in;
    logic [DataWidth:0]   rem_q;
    logic [DataWidth-1:0] quo_q;
    logic [DataWidth-1:0] dvsr_q;
    logic [CntW-1:0]      cnt_q;
    logic [DataWidth-1:0] wb_data_q;

    logic                 in_ready_c;
    logic                 accept;
    logic                 is_signed;
    logic                 div_zero;
    logic                 overflow;
    logic                 fast_path;
    logic [DataWidth-1:0] fast_res;
    logic [DataWidth-1:0] abs_rs1;
    logic [DataWidth-1:0] abs_rs2;

    logic [DataWidth+1:0] diff;
    logic                 fits;
    logic [DataWidth:0]   rem_nxt;
    logic [DataWidth-1:0] quo_nxt;
    logic [DataWidth-1:0] raw_res;
    logic [DataWidth-1:0] fixed_res;

    // Issue-side decode: operand magnitudes, special cases, result sign.
    always_comb begin
        is_signed = ~bus.in_op[0];
        div_zero  = (bus.in_rs2 == '0);
        overflow  = is_signed && (bus.in_rs1 == MinNeg) && (bus.in_rs2 == '1);
        fast_path = div_zero || overflow;

        fast_res = '0;
        if (div_zero) begin
            fast_res = bus.in_op[1] ? bus.in_rs1 : '1;
        end else if (overflow) begin
            fast_res = bus.in_op[1] ? '0 : MinNeg;
        end

        abs_rs1 = (is_signed && bus.in_rs1[DataWidth-1]) ? -bus.in_rs1 : bus.in_rs1;
        abs_rs2 = (is_signed && bus.in_rs2[DataWidth-1]) ? -bus.in_rs2 : bus.in_rs2;

        ctx_in.is_rem   = bus.in_op[1];
        ctx_in.trans_id = bus.in_trans_id;
        ctx_in.neg_res  = bus.in_op[1]
                        ? (is_signed && bus.in_rs1[DataWidth-1])
                        : (is_signed && (bus.in_rs1[DataWidth-1] ^ bus.in_rs2[DataWidth-1]));
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        diff      = {rem_q, quo_q[DataWidth-1]} - {2'b00, dvsr_q};
        fits      = ~diff[DataWidth+1];
        rem_nxt   = fits ? diff[DataWidth:0] : {rem_q[DataWidth-1:0], quo_q[DataWidth-1]};
        quo_nxt   = {quo_q[DataWidth-2:0], fits};
        raw_res   = ctx_q.is_rem ? rem_nxt[DataWidth-1:0] : quo_nxt;
        fixed_res = ctx_q.neg_res ? -raw_res : raw_res;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = ~bus.flush;
                accept     = bus.in_valid && in_ready_c;
                if (accept) begin
                    state_d = fast_path ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ctx_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
        end else if (accept) begin
            ctx_q  <= ctx_in;
            rem_q  <= '0;
            quo_q  <= abs_rs1;
            dvsr_q <= abs_rs2;
            cnt_q  <= '1;
            if (fast_path) begin
                wb_data_q <= fast_res;
            end
        end else if (state_q == CALC && !bus.flush) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                wb_data_q <= fixed_res;
            end
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.wb_valid = (state_q == DONE);
    assign bus.wb_idx   = ctx_q.trans_id;
    assign bus.wb_data  = wb_data_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_div_wb_unit.sv
// Directed bench for div_wb_unit: result values, latency, writeback hold, flush and reset.
module tb_div_wb_unit;
    localparam int SI = 3;
    localparam int DW = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    div_wb_unit_if #(.ScoreboardIndex(SI), .DataWidth(DW)) bus ();

    div_wb_unit #(.ScoreboardIndex(SI), .DataWidth(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [2:0] id);
        bus.in_valid    = 1'b1;
        bus.in_op       = op;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_trans_id = id;
        check({tag, " in_ready@issue"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Called in the cycle after the accept edge; holds wb_ready low for 'hold' DONE cycles.
    task automatic wait_result(input string tag, input logic [2:0] id, input logic [31:0] exp,
                               input int lat, input int hold);
        int cyc = 1;
        while (!bus.wb_valid && cyc < 60) begin
            step();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " wb_idx"}, 32'(bus.wb_idx), 32'(id));
        check({tag, " wb_data"}, bus.wb_data, exp);
        for (int i = 0; i < hold; i++) begin
            check({tag, " hold wb_valid"}, 32'(bus.wb_valid), 32'd1);
            check({tag, " hold wb_idx"}, 32'(bus.wb_idx), 32'(id));
            check({tag, " hold wb_data"}, bus.wb_data, exp);
            check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.wb_ready = 1'b1;
        #1;
        check({tag, " wb_valid@handshake"}, 32'(bus.wb_valid), 32'd1);
        check({tag, " in_ready@handshake"}, 32'(bus.in_ready), 32'd0);
        step();
        check({tag, " wb_valid after"}, 32'(bus.wb_valid), 32'd0);
        check({tag, " in_ready after"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [2:0] id, input logic [31:0] exp,
                       input int lat, input int hold);
        bus.wb_ready = (hold == 0);
        issue(tag, op, rs1, rs2, id);
        wait_result(tag, id, exp, lat, hold);
    endtask

    initial begin
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_op       = 2'b00;
        bus.in_rs1      = '0;
        bus.in_rs2      = '0;
        bus.in_trans_id = '0;
        bus.wb_ready    = 1'b1;

        reset = 1'b0;
        repeat (3) step();
        check("reset wb_valid", 32'(bus.wb_valid), 32'd0);
        check("reset wb_idx", 32'(bus.wb_idx), 32'd0);
        check("reset wb_data", bus.wb_data, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        step();
        check("in_ready after reset", 32'(bus.in_ready), 32'd1);

        // Normal path: unsigned and signed, both sign combinations.
        run("divu 100/7", OP_DIVU, 32'd100, 32'd7, 3'd5, 32'd14, 33, 0);
        run("remu 100/7", OP_REMU, 32'd100, 32'd7, 3'd1, 32'd2, 33, 0);
        run("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 3'd2, 32'hFFFF_FFFD, 33, 0);
        run("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 3'd7, 32'hFFFF_FFFF, 33, 0);
        run("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 3'd0, 32'd1, 33, 0);
        run("div -100/-7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 3'd7, 32'd14, 33, 0);
        run("rem -100/-7", OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 3'd3, 32'hFFFF_FFFE, 33, 0);
        run("divu min/max", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 3'd1, 32'd0, 33, 0);
        run("remu min/max", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 32'h8000_0000, 33, 0);

        // Fast path: divide by zero and signed overflow.
        run("div 5/0", OP_DIV, 32'd5, 32'd0, 3'd6, 32'hFFFF_FFFF, 1, 0);
        run("remu 5/0", OP_REMU, 32'd5, 32'd0, 3'd3, 32'd5, 1, 0);
        run("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'h8000_0000, 1, 0);
        run("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 32'd0, 1, 0);

        // Writeback backpressure for 10 cycles.
        run("div hold", OP_DIV, 32'd1000, 32'hFFFF_FFF6, 3'd1, 32'hFFFF_FF9C, 33, 10);

        // Flush in the 10th CALC cycle, new op presented in the same cycle.
        bus.wb_ready = 1'b1;
        issue("flush victim", OP_DIVU, 32'd100, 32'd7, 3'd3);
        repeat (9) step();
        bus.flush       = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_op       = OP_REMU;
        bus.in_rs1      = 32'd1000;
        bus.in_rs2      = 32'd7;
        bus.in_trans_id = 3'd6;
        #1;
        check("flush in_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.flush = 1'b0;
        #1;
        check("post-flush wb_valid", 32'(bus.wb_valid), 32'd0);
        check("post-flush busy", 32'(bus.busy), 32'd0);
        check("post-flush in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        wait_result("after flush", 3'd6, 32'd6, 33, 0);

        // Reset in the middle of CALC.
        issue("reset victim", OP_DIV, 32'hFFFF_FF9C, 32'd7, 3'd4);
        repeat (4) step();
        reset = 1'b0;
        step();
        check("mid reset wb_valid", 32'(bus.wb_valid), 32'd0);
        check("mid reset wb_idx", 32'(bus.wb_idx), 32'd0);
        check("mid reset wb_data", bus.wb_data, 32'd0);
        check("mid reset busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        step();
        check("in_ready after mid reset", 32'(bus.in_ready), 32'd1);
        run("div -100/7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 3'd4, 32'hFFFF_FFF2, 33, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
